// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its debounce FSM.
// Key codes are {row_idx, col_idx} on a 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D layout.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } deb_state_t;

   typedef enum logic [1:0] {
      FC_NONE,
      FC_SINGLE,
      FC_MULTI
   } frame_class_t;

   typedef struct packed {
      frame_class_t cls;
      logic [3:0]   code;
   } frame_info_t;

   localparam logic [3:0] KEY_1      = 4'h0;
   localparam logic [3:0] KEY_2      = 4'h1;
   localparam logic [3:0] KEY_3      = 4'h2;
   localparam logic [3:0] KEY_MODE   = 4'h3;
   localparam logic [3:0] KEY_4      = 4'h4;
   localparam logic [3:0] KEY_5      = 4'h5;
   localparam logic [3:0] KEY_6      = 4'h6;
   localparam logic [3:0] KEY_HH     = 4'h7;
   localparam logic [3:0] KEY_7      = 4'h8;
   localparam logic [3:0] KEY_8      = 4'h9;
   localparam logic [3:0] KEY_9      = 4'hA;
   localparam logic [3:0] KEY_MM     = 4'hB;
   localparam logic [3:0] KEY_0      = 4'hD;
   localparam logic [3:0] KEY_SWITCH = 4'hF;

   // The code field is only meaningful for FC_SINGLE.
   function automatic frame_info_t classify_frame(input logic [15:0] pressed);
      frame_info_t info;
      int unsigned n;
      n         = 0;
      info.code = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (pressed[i]) begin
            n++;
            info.code = 4'(i);
         end
      end
      if (n == 0)      info.cls = FC_NONE;
      else if (n == 1) info.cls = FC_SINGLE;
      else             info.cls = FC_MULTI;
      return info;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level press/release FSM: turns one classified frame per strobe into a
// single key_valid pulse per press and a key_held level until release.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEB_SCANS = 4
) (
   input  logic       ck,
   input  logic       reset,
   input  logic       frame_stb,
   input  logic [1:0] frame_cls,
   input  logic [3:0] frame_code,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(DEB_SCANS + 1);

   deb_state_t    state, state_nx;
   logic [3:0]    cand, cand_nx;
   logic [CW-1:0] deb_cnt, deb_cnt_nx, deb_cnt_inc;
   logic          cnt_hit, accept, accept_q;
   logic          is_single, is_none;

   assign is_single   = (frame_cls == FC_SINGLE);
   assign is_none     = (frame_cls == FC_NONE);
   assign cnt_hit     = (deb_cnt >= CW'(DEB_SCANS - 1));
   assign deb_cnt_inc = (deb_cnt < CW'(DEB_SCANS)) ? deb_cnt + 1'b1 : deb_cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // NOTE: every comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx   = state;
      cand_nx    = cand;
      deb_cnt_nx = deb_cnt;
      accept     = 1'b0;
      if (frame_stb) begin
         unique case (state)
            ST_IDLE: begin
               if (is_single) begin
                  cand_nx    = frame_code;
                  deb_cnt_nx = CW'(1);
                  if (DEB_SCANS == 1) begin
                     accept   = 1'b1;
                     state_nx = ST_PRESSED;
                  end else begin
                     state_nx = ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (is_single && frame_code == cand) begin
                  deb_cnt_nx = deb_cnt_inc;
                  if (cnt_hit) begin
                     accept   = 1'b1;
                     state_nx = ST_PRESSED;
                  end
               end else if (is_single) begin
                  cand_nx    = frame_code;
                  deb_cnt_nx = CW'(1);
               end else begin
                  state_nx = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               // A multi-key frame counts as "still held", never as a release.
               if (is_none) begin
                  deb_cnt_nx = CW'(1);
                  state_nx   = (DEB_SCANS == 1) ? ST_IDLE : ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (is_none) begin
                  deb_cnt_nx = deb_cnt_inc;
                  if (cnt_hit) state_nx = ST_IDLE;
               end else begin
                  state_nx = ST_PRESSED;
               end
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         cand     <= 4'h0;
         deb_cnt  <= '0;
         key_code <= 4'h0;
         accept_q <= 1'b0;
      end else begin
         cand     <= cand_nx;
         deb_cnt  <= deb_cnt_nx;
         accept_q <= accept;
         if (accept) key_code <= cand_nx;
      end
   end

   always_comb begin
      key_valid = accept_q;
      key_held  = (state == ST_PRESSED) || (state == ST_RELEASE);
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: rotates column strobes, synchronizes rows,
// accumulates one 16-bit frame per column sweep and feeds the debounce FSM.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV  = 25000,
   parameter int DEB_SCANS = 4
) (
   input  logic       ck,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SW = $clog2(SCAN_DIV);

   logic [3:0]    row_s1, row_s2;
   logic [SW-1:0] slot_cnt;
   logic [1:0]    col_idx;
   logic [15:0]   acc, frame_vec;
   logic          slot_end, frame_stb;
   frame_info_t   info;

   assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
   assign frame_stb = slot_end && (col_idx == 2'd3);

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row;
         row_s2 <= row_s1;
      end
   end

   // col is a register rather than a decode of col_idx so the strobes never glitch.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         slot_cnt <= '0;
         col_idx  <= 2'd0;
         col      <= 4'b1110;
      end else if (slot_end) begin
         slot_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         col      <= {col[2:0], col[3]};
      end else begin
         slot_cnt <= slot_cnt + 1'b1;
      end
   end

   // Current column's rows merged in, so the frame is complete on the column-3 strobe.
   always_comb begin
      frame_vec = acc;
      for (int r = 0; r < 4; r++) begin
         frame_vec[{r[1:0], col_idx}] = ~row_s2[r];
      end
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset)          acc <= '0;
      else if (frame_stb) acc <= '0;
      else if (slot_end)  acc <= frame_vec;
   end

   assign info = classify_frame(frame_vec);

   keypad_debounce #(
      .DEB_SCANS(DEB_SCANS)
   ) u_debounce (
      .ck        (ck),
      .reset     (reset),
      .frame_stb (frame_stb),
      .frame_cls (info.cls),
      .frame_code(info.code),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan with SCAN_DIV=4, DEB_SCANS=2 (16-cycle frames).
// A key model pulls a row low while its column strobe is low.
module tb_keypad_scan;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_SCANS = 2;

   typedef struct {
      logic [3:0] code;
      int         at;
   } event_t;

   logic        ck = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row, col, key_code;
   logic        key_valid, key_held;
   logic [15:0] press_mask = 16'h0000;
   logic        prev_valid = 1'b0;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   event_t      sb[$];
   logic [3:0]  col_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   keypad_scan #(
      .SCAN_DIV (SCAN_DIV),
      .DEB_SCANS(DEB_SCANS)
   ) dut (
      .ck       (ck),
      .reset    (reset),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 ck = ~ck;

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press_mask[r*4 + c] && !col[c]) row[r] = 1'b0;
   end

   // Edges since reset release; sampled on negedges it equals the last posedge number.
   always @(posedge ck or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_event(input logic [3:0] code, input int at);
      event_t e;
      e.code = code;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge ck);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge ck);
      reset = 1'b0;
   endtask

   task automatic reset_mid_cycle_and_check(input string tag);
      @(posedge ck);
      #3 reset = 1'b1;
      #1;
      check({tag, "_col"},       col,       4'b1110);
      check({tag, "_key_code"},  key_code,  4'h0);
      check({tag, "_key_valid"}, key_valid, 1'b0);
      check({tag, "_key_held"},  key_held,  1'b0);
      repeat (2) @(negedge ck);
      reset = 1'b0;
   endtask

   // Monitor: every key_valid pulse must match the next queued event.
   always @(negedge ck) begin
      event_t e;
      if (!reset) begin
         if (key_valid && prev_valid) begin
            n_checks++;
            $display("FAIL valid_width: key_valid high two cycles in a row at cyc %0d", cyc);
         end
         if (key_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pulse: key_code=0x%0h at cyc %0d, no event expected", key_code, cyc);
            end else begin
               e = sb.pop_front();
               check("pulse_code",  key_code, e.code);
               check("pulse_cycle", cyc,      e.at);
            end
         end
      end
      prev_valid = key_valid;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached with %0d events pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset mid-frame, then the column rotation from a clean start
      press_mask = 16'h0000;
      do_reset();
      wait_cyc(22);
      reset_mid_cycle_and_check("t1_rst");
      for (int k = 0; k < 16; k++) begin
         wait_cyc(k);
         check("t1_col", col, col_tab[k / 4]);
      end

      // 2: row2/col1 held 4 frames, accepted at end of frame 2, released after 2 frames
      press_mask = 16'h0200;
      do_reset();
      expect_event(4'h9, 32);
      wait_cyc(40);
      check("t2_code", key_code, 4'h9);
      check("t2_held", key_held, 1'b1);
      wait_cyc(64);
      press_mask = 16'h0000;
      wait_cyc(95);
      check("t2_held_before_release", key_held, 1'b1);
      wait_cyc(96);
      check("t2_held_after_release", key_held, 1'b0);
      check("t2_pending", sb.size(), 0);

      // 3: key toggling every frame never debounces
      press_mask = 16'h0200;
      do_reset();
      for (int f = 1; f <= 5; f++) begin
         wait_cyc(16 * f);
         press_mask = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      end
      wait_cyc(100);
      check("t3_held", key_held, 1'b0);
      check("t3_code", key_code, 4'h0);

      // 4: row0/col0 + row3/col3 together, then only row0/col0
      press_mask = 16'h8001;
      do_reset();
      expect_event(4'h0, 80);
      wait_cyc(47);
      check("t4_multi_held", key_held, 1'b0);
      wait_cyc(48);
      press_mask = 16'h0001;
      wait_cyc(90);
      check("t4_held", key_held, 1'b1);
      check("t4_code", key_code, 4'h0);
      wait_cyc(96);
      press_mask = 16'h0000;
      wait_cyc(130);
      check("t4_released", key_held, 1'b0);
      check("t4_pending", sb.size(), 0);

      // 5: row1/col2 accepted, slide to row1/col3 without a gap, then release
      press_mask = 16'h0040;
      do_reset();
      expect_event(4'h6, 32);
      wait_cyc(48);
      press_mask = 16'h0080;
      wait_cyc(79);
      check("t5_code_kept", key_code, 4'h6);
      check("t5_held",      key_held, 1'b1);
      wait_cyc(80);
      press_mask = 16'h0000;
      wait_cyc(111);
      check("t5_held_before_release", key_held, 1'b1);
      wait_cyc(112);
      check("t5_released",  key_held, 1'b0);
      check("t5_code_after", key_code, 4'h6);
      check("t5_pending", sb.size(), 0);

      // 6: reset while held; the still-pressed key is re-detected
      press_mask = 16'h0200;
      do_reset();
      expect_event(4'h9, 32);
      wait_cyc(40);
      check("t6_held_pre", key_held, 1'b1);
      reset_mid_cycle_and_check("t6_rst");
      expect_event(4'h9, 32);
      wait_cyc(31);
      check("t6_held_mid", key_held, 1'b0);
      wait_cyc(40);
      check("t6_code", key_code, 4'h9);
      check("t6_held", key_held, 1'b1);
      check("t6_pending", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Scans a 4x4 active-low key matrix and delivers debounced, single-key press events to the clock/alarm setting logic. It is the input-side counterpart of the multiplexed four-digit display driver:
- the display drives anodes and writes segments;
- this block drives column strobes and reads row lines.

One event is produced per press. Holding a key gives no repeat, and releasing it is tracked separately.

Parameters:
SCAN_DIV, 25000, clock cycles per column slot (must be >= 4); one frame = 4*SCAN_DIV cycles
DEB_SCANS, 4, consecutive identical frames required to accept a press or a release (>= 1)

Ports:
ck  in  1  system clock
reset  in  1  asynchronous, active-high reset
row  in  4  matrix row lines, active-low, externally pulled up, asynchronous to ck
col  out  4  column strobes, active-low, exactly one low at any time
key_code  out  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}
key_valid  out  1  one-cycle pulse when a new press is accepted
key_held  out  1  high from accept until release is accepted

Behaviour:
- Reset values (asynchronous): col=4'b1110, key_code=0, key_valid=0, key_held=0, state IDLE, all counters 0, frame accumulator cleared.
- Row input: row passes through a 2-flop synchronizer before any use.
- Column slot timing:
  - Slot counter runs 0..SCAN_DIV-1.
  - In the last cycle of a slot, the synchronized, inverted row vector is stored for the current column.
  - The column then advances 0->1->2->3->0, rotating the low bit of col (1110, 1101, 1011, 0111).
  - Settle margin is SCAN_DIV-1 cycles, which is >= 2 synchronizer cycles.
- Frame evaluation:
  - Happens at the end of the column-3 slot.
  - Count pressed bits across all 16 positions.
  - Frame class is NONE (0 pressed), SINGLE(code) (exactly 1), or MULTI (>1).
  - MULTI is treated as NONE for press acceptance and as "not released" while in PRESSED.
  - The accumulator clears for the next frame.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. Debounce counter deb_cnt is sized for DEB_SCANS.
  - IDLE:
    - SINGLE(c): cand=c, deb_cnt=1.
    - If DEB_SCANS==1, accept immediately; otherwise go to DEBOUNCE.
  - DEBOUNCE:
    - SINGLE(cand): deb_cnt++. When deb_cnt reaches DEB_SCANS, accept.
    - SINGLE(other): cand=other, deb_cnt=1.
    - NONE or MULTI: return to IDLE.
  - Accept:
    - In the cycle after the frame-evaluation cycle: key_code<=cand, key_valid=1 for exactly one cycle, key_held<=1.
    - Next state PRESSED.
  - PRESSED:
    - NONE frame: deb_cnt=1, go to RELEASE (or, if DEB_SCANS==1, release directly to IDLE).
    - SINGLE(any) or MULTI: stay. A key change while held generates no event.
  - RELEASE:
    - NONE: deb_cnt++. When deb_cnt reaches DEB_SCANS: key_held<=0, go to IDLE.
    - Any key: back to PRESSED.
- Output retention: key_code holds its value until the next accept. key_valid is never high in two consecutive cycles. Latency from a stable press to key_valid is at most (DEB_SCANS+1) frames + 1 cycle.
- Reset mid-operation (including mid-debounce or while held):
  - All state returns to reset values and no pulse is emitted.
  - A key still held after reset is re-detected and produces a fresh event after DEB_SCANS frames.
- Counter wrap: slot and column counters wrap freely. deb_cnt saturates and never wraps.

Decomposition:
- Shared package keypad_pkg holds:
  - the FSM state enum;
  - the frame-class encoding (NONE/SINGLE/MULTI);
  - key-code constants for the clock UI: KEY_MODE, KEY_HH, KEY_MM, KEY_SWITCH, digits 0-9.
- One natural sub-module, keypad_debounce: the frame-level FSM. It takes the frame class and code plus a frame strobe, and produces key_code, key_valid and key_held.
- Scan timing, column rotation, synchronizer and accumulator stay in keypad_scan.

Test Plan:
All scenarios use SCAN_DIV=4, DEB_SCANS=2, so one frame = 16 cycles.
1. Reset asserted mid-frame: col=1110, key_code=0, key_valid=0, key_held=0 immediately, without waiting for a ck edge. After release, col visits 1110, 1101, 1011, 0111 in turn, each for 4 cycles.
2. Press row2/col1 (model drives row[2]=0 whenever col[1]=0) for 4 frames, then release:
   - exactly one key_valid pulse, at the end of frame 2 + 1 cycle;
   - key_code=4'b1001;
   - key_held falls 2 frames after release.
3. Bounce: the key toggles every frame for 5 frames (SINGLE, NONE, SINGLE, ...): no key_valid, key_held=0.
4. Two keys held together, row0/col0 and row3/col3: no event. After row3/col3 is released and row0/col0 stays held: one event with key_code=4'b0000.
5. Holding row1/col2 accepts it (key_code=4'b0110). Switching directly to row1/col3 without a NONE frame gives no second pulse and key_code stays 4'b0110. After 2 NONE frames, key_held=0.
6. Reset asserted while key_held=1 and the key is still pressed: outputs clear. After reset, a new pulse arrives at frame 2 with the same code.
